// File: rtl/button_conditioner.sv
// button_conditioner: synchronizes and debounces a raw push-button into a clean level, edge pulses, a long-press pulse and a press counter.
module button_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int COUNT_W         = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               button_raw,
  output logic               button_level,
  output logic               press_pulse,
  output logic               release_pulse,
  output logic               long_press_pulse,
  output logic [COUNT_W-1:0] press_count
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
  state_t               state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [DW-1:0]        deb_q, deb_d;
  logic [HW-1:0]        hold_q, hold_d;
  logic                 fired_q, fired_d;
  logic                 level_q, level_d;
  logic                 press_q, press_d;
  logic                 release_q, release_d;
  logic                 long_q, long_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 s, accept_press, accept_release;
  assign s              = sync_q[SYNC_STAGES-1];
  assign accept_press   = (state_q == PRESS_WAIT) && s && (deb_q == DEB_MAX);
  assign accept_release = (state_q == RELEASE_WAIT) && !s && (deb_q == DEB_MAX);
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= '0;
      state_q   <= IDLE;
      deb_q     <= '0;
      hold_q    <= '0;
      fired_q   <= 1'b0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], button_raw};
      state_q   <= state_d;
      deb_q     <= deb_d;
      hold_q    <= hold_d;
      fired_q   <= fired_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      count_q   <= count_d;
    end
  end
  always_comb begin
    state_d = state_q;
    deb_d   = deb_q;
    unique case (state_q)
      IDLE: begin
        state_d = s ? PRESS_WAIT : IDLE;
        deb_d   = s ? DW'(1) : '0;
      end
      PRESS_WAIT: begin
        state_d = !s ? IDLE : accept_press ? PRESSED : PRESS_WAIT;
        deb_d   = (!s || accept_press) ? '0 : deb_q + DW'(1);
      end
      PRESSED: begin
        state_d = s ? PRESSED : RELEASE_WAIT;
        deb_d   = s ? '0 : DW'(1);
      end
      RELEASE_WAIT: begin
        state_d = s ? PRESSED : accept_release ? IDLE : RELEASE_WAIT;
        deb_d   = (s || accept_release) ? '0 : deb_q + DW'(1);
      end
      default: begin
        state_d = IDLE;
        deb_d   = '0;
      end
    endcase
  end
  // Hold time only accumulates in PRESSED; a bounce through RELEASE_WAIT keeps it frozen.
  always_comb begin
    hold_d    = accept_press ? '0
              : ((state_q == PRESSED) && s && (hold_q != HOLD_MAX)) ? hold_q + HW'(1)
              : hold_q;
    long_d    = (state_q == PRESSED) && s && (hold_d == HOLD_MAX) && !fired_q;
    fired_d   = accept_press ? 1'b0 : (fired_q | long_d);
    level_d   = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    press_d   = accept_press;
    release_d = accept_release;
    count_d   = count_q + COUNT_W'(accept_press);
  end
  assign button_level     = level_q;
  assign press_pulse      = press_q;
  assign release_pulse    = release_q;
  assign long_press_pulse = long_q;
  assign press_count      = count_q;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed and random checks of button_conditioner against a run-length reference model.
module tb_button_conditioner;
  localparam int SYNC = 2, DEB = 4, HOLD = 10, CW = 8;
  logic clk = 1'b0, reset = 1'b1, button_raw = 1'b0;
  logic button_level, press_pulse, release_pulse, long_press_pulse;
  logic [CW-1:0] press_count;
  int checks = 0, failures = 0;
  int npress = 0, nrel = 0, nlong = 0;
  bit hist [SYNC];
  bit m_l, m_prev, m_fired, e_press, e_rel, e_long;
  int m_run, m_hold, m_count;
  always #5 clk = ~clk;
  button_conditioner #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD), .COUNT_W(CW)) dut (
    .clk(clk), .reset(reset), .button_raw(button_raw), .button_level(button_level),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_press_pulse(long_press_pulse), .press_count(press_count)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  // Accepted level flips once DEB consecutive synchronized samples disagree with it.
  task automatic model_edge();
    bit s;
    if (reset) begin
      foreach (hist[i]) hist[i] = 1'b0;
      {m_l, m_prev, m_fired, e_press, e_rel, e_long} = '0;
      m_run = 0; m_hold = 0; m_count = 0;
    end else begin
      s = hist[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = button_raw;
      {e_press, e_rel, e_long} = '0;
      if (m_l && s && m_prev && m_hold < HOLD) m_hold++;
      if (m_l && m_hold == HOLD && !m_fired) begin
        e_long = 1'b1;
        m_fired = 1'b1;
      end
      m_run = (s != m_l) ? m_run + 1 : 0;
      if (m_run == DEB) begin
        m_run = 0;
        m_l = !m_l;
        if (m_l) begin
          e_press = 1'b1;
          m_count = (m_count + 1) % (1 << CW);
          m_hold = 0;
          m_fired = 1'b0;
        end else e_rel = 1'b1;
      end
      m_prev = s;
    end
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("level", button_level, m_l);
    check("press", press_pulse, e_press);
    check("release", release_pulse, e_rel);
    check("long", long_press_pulse, e_long);
    check("count", press_count, m_count);
    check("press_rel_excl", press_pulse & release_pulse, 0);
    npress += press_pulse;
    nrel += release_pulse;
    nlong += long_press_pulse;
  endtask
  initial begin
    reset = 1'b1;
    repeat (3) step();
    check("rst_level", button_level, 0);
    check("rst_count", press_count, 0);
    reset = 1'b0;
    button_raw = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      check("t1_press_at5", press_pulse, k == 5);
    end
    check("t1_level", button_level, 1);
    check("t1_count", press_count, 1);
    button_raw = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      check("t2_release_at5", release_pulse, k == 5);
    end
    check("t2_level", button_level, 0);
    check("t2_count", press_count, 1);
    npress = 0; nrel = 0; nlong = 0;
    for (int k = 0; k < 4; k++) begin
      button_raw = (k % 2 == 0);
      step();
    end
    button_raw = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      check("t3_press_at5", press_pulse, k == 5);
      check("t4_long_at15", long_press_pulse, k == 15);
    end
    check("t3_npress", npress, 1);
    button_raw = 1'b0;
    repeat (2) step();
    button_raw = 1'b1;
    repeat (16) step();
    check("t4_nlong", nlong, 1);
    check("t4_nrel", nrel, 0);
    check("t4_npress", npress, 1);
    button_raw = 1'b0;
    repeat (8) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      button_raw = 1'b1;
      repeat (6) step();
      button_raw = 1'b0;
      repeat (6) step();
    end
    check("t5_wrap", press_count, 0);
    button_raw = 1'b1;
    repeat (6) step();
    check("t5_after_wrap", press_count, 1);
    nrel = 0;
    reset = 1'b1;
    step();
    check("t6_level", button_level, 0);
    check("t6_press", press_pulse, 0);
    check("t6_release", release_pulse, 0);
    check("t6_long", long_press_pulse, 0);
    check("t6_count", press_count, 0);
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      check("t6_press_at5", press_pulse, k == 5);
    end
    check("t6_count_after", press_count, 1);
    check("t6_nrel", nrel, 0);
    for (int n = 0; n < 600; n++) begin
      button_raw = ($urandom_range(1, 0) == 1);
      reset = ($urandom_range(199, 0) == 0);
      repeat ($urandom_range(($urandom_range(3, 0) == 0) ? 20 : 6, 1)) step();
    end
    reset = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
